// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the main FSM state encoding and the primary opcode constants.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/main_controller.sv
// Moore FSM sequencing the multicycle MIPS datapath; the state code is
// the registered output, decoded into enables/selects further downstream.
module main_controller
  import mips_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic [3:0] state
);

  state_t state_r;
  state_t next_s;

  // Next-state selection; opcode only matters in DECODE and MEMADR.
  always_comb begin
    next_s = FETCH;
    case (state_r)
      FETCH: next_s = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_s = MEMADR;
          OP_RTYPE:     next_s = EXECUTE;
          OP_BEQ:       next_s = BRANCH;
          OP_ADDI:      next_s = ADDIEX;
          OP_J:         next_s = JUMP;
          default:      next_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW) begin
          next_s = MEMRD;
        end else if (opcode == OP_SW) begin
          next_s = MEMWR;
        end else begin
          next_s = FETCH;
        end
      end
      MEMRD:   next_s = MEMWB;
      EXECUTE: next_s = ALUWB;
      ADDIEX:  next_s = ADDIWB;
      // Terminal states and the unused codes 12..15 all return to FETCH.
      default: next_s = FETCH;
    endcase
  end

  // State register with asynchronous active-low reset to FETCH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_main_controller.sv
// Directed, table-driven check of the main controller state sequences.
module tb_main_controller;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic [3:0] state;

  int checks = 0;
  int fails  = 0;

  main_controller dut (
    .clock  (clock),
    .reset  (reset),
    .opcode (opcode),
    .state  (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [5:0]  op;
    int          edges;
    logic [23:0] seq;   // nibble k = expected state after k rising edges
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: state=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{"lw",      6'b100011, 5, 24'h043210};
    vecs[1] = '{"sw",      6'b101011, 4, 24'h005210};
    vecs[2] = '{"rtype",   6'b000000, 4, 24'h007610};
    vecs[3] = '{"addi",    6'b001000, 4, 24'h00a910};
    vecs[4] = '{"beq",     6'b000100, 3, 24'h000810};
    vecs[5] = '{"j",       6'b000010, 3, 24'h000b10};
    vecs[6] = '{"ill_3f",  6'b111111, 2, 24'h000010};
    vecs[7] = '{"ill_01",  6'b000001, 2, 24'h000010};
    vecs[8] = '{"lw_again",6'b100011, 5, 24'h043210};

    reset  = 1'b1;
    opcode = 6'b000000;
    repeat (2) @(posedge clock);

    // Asynchronous reset asserted mid-cycle takes effect immediately.
    #3 reset = 1'b0;
    #1 check("reset_async", state, 4'd0);
    repeat (2) begin
      @(negedge clock);
      check("reset_hold", state, 4'd0);
    end
    reset = 1'b1;
    check("reset_release", state, 4'd0);

    for (int v = 0; v < 9; v++) begin
      opcode = vecs[v].op;
      check($sformatf("%s step 0", vecs[v].name), state, vecs[v].seq[3:0]);
      for (int k = 1; k <= vecs[v].edges; k++) begin
        @(negedge clock);
        check($sformatf("%s step %0d", vecs[v].name, k), state, vecs[v].seq[4*k +: 4]);
      end
    end

    // MEMADR with an opcode that is neither LW nor SW falls back to FETCH.
    opcode = 6'b100011;
    @(negedge clock); check("memadr_other s1", state, 4'd1);
    @(negedge clock); check("memadr_other s2", state, 4'd2);
    opcode = 6'b000000;
    @(negedge clock); check("memadr_other s3", state, 4'd0);

    // Opcode changes outside DECODE/MEMADR are ignored.
    opcode = 6'b100011;
    @(negedge clock); check("ignore s1", state, 4'd1);
    @(negedge clock); check("ignore s2", state, 4'd2);
    @(negedge clock); check("ignore s3", state, 4'd3);
    opcode = 6'b101011;
    @(negedge clock); check("ignore s4", state, 4'd4);
    opcode = 6'b000000;
    @(negedge clock); check("ignore s5", state, 4'd0);

    // Reset pulse while in MEMRD aborts the instruction.
    opcode = 6'b100011;
    @(negedge clock); check("midrst s1", state, 4'd1);
    @(negedge clock); check("midrst s2", state, 4'd2);
    @(negedge clock); check("midrst s3", state, 4'd3);
    #2 reset = 1'b0;
    #1 check("midrst async", state, 4'd0);
    @(negedge clock); check("midrst held", state, 4'd0);
    reset = 1'b1;
    @(negedge clock); check("midrst first edge", state, 4'd1);
    @(negedge clock); check("midrst resume s2", state, 4'd2);
    @(negedge clock); check("midrst resume s3", state, 4'd3);
    @(negedge clock); check("midrst resume s4", state, 4'd4);
    @(negedge clock); check("midrst resume s5", state, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
